// File: rtl/vga_plot_arbiter_pkg.sv
// Shared definitions for the VGA plot arbiter and the pixel producers
// that feed it: arbiter state encodings, screen geometry, pixel field widths.
package vga_plot_arbiter_pkg;

  localparam int VGA_X_W   = 9;
  localparam int VGA_Y_W   = 8;
  localparam int VGA_C_W   = 3;
  localparam int VGA_H_RES = 320;
  localparam int VGA_V_RES = 240;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Requester-side bus of the plot arbiter: per-producer request/done,
// packed pixel streams, and the one-hot grant returned to the producers.
interface vga_plot_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int X_W     = vga_plot_arbiter_pkg::VGA_X_W,
  parameter int Y_W     = vga_plot_arbiter_pkg::VGA_Y_W,
  parameter int C_W     = vga_plot_arbiter_pkg::VGA_C_W
);

  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     done;
  logic [NUM_REQ-1:0]     plot_in;
  logic [NUM_REQ*X_W-1:0] x_in;
  logic [NUM_REQ*Y_W-1:0] y_in;
  logic [NUM_REQ*C_W-1:0] color_in;
  logic [NUM_REQ-1:0]     grant;

  // Producers drive the pixel streams and observe the grant.
  modport master (
    output req, done, plot_in, x_in, y_in, color_in,
    input  grant
  );

  // The arbiter consumes the pixel streams and drives the grant.
  modport slave (
    input  req, done, plot_in, x_in, y_in, color_in,
    output grant
  );

endinterface

// File: rtl/vga_plot_arbiter_rr_priority_picker.sv
// Combinational winner selection: requester 0 always wins when asking,
// otherwise round-robin over 1..NUM_REQ-1 starting at rr_ptr.
module vga_plot_arbiter_rr_priority_picker
  import vga_plot_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               win_valid,
  output logic [IDX_W-1:0]   win_idx,
  output logic [NUM_REQ-1:0] win_onehot
);

  // Size of the round-robin ring (indices 1..NUM_REQ-1).
  localparam int NRR = (NUM_REQ > 1) ? NUM_REQ - 1 : 1;

  int base;
  int cand;

  // Scan the ring from rr_ptr with wrap back to index 1; an out-of-range
  // pointer is treated as 1 so the scan is always well defined.
  always_comb begin
    win_valid  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand       = 0;
    base       = ((int'(rr_ptr) >= 1) && (int'(rr_ptr) < NUM_REQ)) ? int'(rr_ptr) - 1 : 0;
    if (req[0]) begin
      win_valid = 1'b1;
      win_idx   = '0;
    end else if (NUM_REQ > 1) begin
      for (int k = 0; k < NRR; k++) begin
        cand = 1 + ((base + k) % NRR);
        if (!win_valid && req[IDX_W'(cand)]) begin
          win_valid = 1'b1;
          win_idx   = IDX_W'(cand);
        end
      end
    end
    if (win_valid) begin
      win_onehot[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Burst-level arbiter for the single VGA framebuffer write port.
// One producer owns the port per burst; its pixels are registered through
// with screen-bounds clipping, and a watchdog forces release of a stuck burst.
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int X_W     = VGA_X_W,
  parameter int Y_W     = VGA_Y_W,
  parameter int C_W     = VGA_C_W,
  parameter int H_RES   = VGA_H_RES,
  parameter int V_RES   = VGA_V_RES,
  parameter int TIMEOUT = 131072
) (
  input  logic               clock,
  input  logic               resetn,
  vga_plot_arbiter_if.slave  bus,
  output logic               vga_plot,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [C_W-1:0]     vga_color,
  output logic               busy,
  output logic [NUM_REQ-1:0] timeout_err
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int WD_W  = idx_w(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_MAX  = {WD_W{1'b1}};
  localparam logic [IDX_W-1:0] RR_FIRST = IDX_W'(1);
  localparam logic [IDX_W-1:0] RR_LAST  = IDX_W'(NUM_REQ - 1);

  // A pixel is written only when it lands inside the visible area.
  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (32'(x) < 32'(H_RES)) && (32'(y) < 32'(V_RES));
  endfunction

  logic [1:0]         state_d, state_q;
  logic [NUM_REQ-1:0] grant_d, grant_q;
  logic [IDX_W-1:0]   owner_d, owner_q;
  logic [IDX_W-1:0]   rr_ptr_d, rr_ptr_q;
  logic [WD_W-1:0]    wd_d, wd_q;
  logic [NUM_REQ-1:0] terr_d, terr_q;
  logic               vplot_d, vplot_q;
  logic [X_W-1:0]     vx_d, vx_q;
  logic [Y_W-1:0]     vy_d, vy_q;
  logic [C_W-1:0]     vc_d, vc_q;

  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;

  logic               own_plot;
  logic               own_req;
  logic               own_done;
  logic [X_W-1:0]     own_x;
  logic [Y_W-1:0]     own_y;
  logic [C_W-1:0]     own_c;
  logic               burst_end;
  logic               wd_hit;

  vga_plot_arbiter_rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (bus.req),
    .rr_ptr     (rr_ptr_q),
    .win_valid  (win_valid),
    .win_idx    (win_idx),
    .win_onehot (win_onehot)
  );

  // Select the current owner's stream; other producers are ignored.
  always_comb begin
    own_plot  = bus.plot_in[owner_q];
    own_req   = bus.req[owner_q];
    own_done  = bus.done[owner_q];
    own_x     = bus.x_in[owner_q*X_W +: X_W];
    own_y     = bus.y_in[owner_q*Y_W +: Y_W];
    own_c     = bus.color_in[owner_q*C_W +: C_W];
    wd_hit    = (wd_q == WD_LAST);
    burst_end = own_done || !own_req || wd_hit;
  end

  // Arbiter FSM, watchdog, round-robin pointer and pixel pass-through.
  // The pixel presented in the final GRANT cycle is still forwarded;
  // coordinates follow every presented pixel, even a clipped one.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    wd_d     = wd_q;
    terr_d   = terr_q;
    vplot_d  = 1'b0;
    vx_d     = vx_q;
    vy_d     = vy_q;
    vc_d     = vc_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_GRANT;
          grant_d = win_onehot;
          owner_d = win_idx;
          wd_d    = '0;
        end
      end
      ST_GRANT: begin
        if (own_plot) begin
          vplot_d = on_screen(own_x, own_y);
          vx_d    = own_x;
          vy_d    = own_y;
          vc_d    = own_c;
        end
        if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
        if (burst_end) begin
          state_d = ST_RELEASE;
          grant_d = '0;
          if (wd_hit) begin
            terr_d[owner_q] = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        if (owner_q != '0) begin
          rr_ptr_d = (owner_q == RR_LAST) ? RR_FIRST : owner_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= RR_FIRST;
      wd_q     <= '0;
      terr_q   <= '0;
      vplot_q  <= 1'b0;
      vx_q     <= '0;
      vy_q     <= '0;
      vc_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      wd_q     <= wd_d;
      terr_q   <= terr_d;
      vplot_q  <= vplot_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      vc_q     <= vc_d;
    end
  end

  assign bus.grant   = grant_q;
  assign vga_plot    = vplot_q;
  assign vga_x       = vx_q;
  assign vga_y       = vy_q;
  assign vga_color   = vc_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed vector table, hand-written burst
// sequences, then randomized traffic against a burst-level reference model.
module tb_vga_plot_arbiter;

  localparam int NUM_REQ = 3;
  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int C_W     = 3;
  localparam int H_RES   = 320;
  localparam int V_RES   = 240;
  localparam int TIMEOUT = 8;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  vga_plot_arbiter_if #(.NUM_REQ(NUM_REQ), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) bus();

  logic               vga_plot;
  logic [X_W-1:0]     vga_x;
  logic [Y_W-1:0]     vga_y;
  logic [C_W-1:0]     vga_color;
  logic               busy;
  logic [NUM_REQ-1:0] timeout_err;

  vga_plot_arbiter #(
    .NUM_REQ (NUM_REQ), .X_W (X_W), .Y_W (Y_W), .C_W (C_W),
    .H_RES (H_RES), .V_RES (V_RES), .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .bus         (bus.slave),
    .vga_plot    (vga_plot),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_color   (vga_color),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the port (-1 = nobody), whether the port is in
  // its mandatory turnaround cycle, how long the current burst has run.
  int                 m_owner;
  bit                 m_rel;
  int                 m_age;
  int                 m_rr;
  logic [NUM_REQ-1:0] m_grant;
  logic               m_plot;
  logic [X_W-1:0]     m_x;
  logic [Y_W-1:0]     m_y;
  logic [C_W-1:0]     m_c;
  logic [NUM_REQ-1:0] m_terr;
  logic               m_busy;

  function automatic int pick();
    int idx;
    if (bus.req[0]) return 0;
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      idx = 1 + ((m_rr - 1 + k) % (NUM_REQ - 1));
      if (bus.req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    int o;
    if (!resetn) begin
      m_owner = -1; m_rel = 0; m_age = 0; m_rr = 1;
      m_grant = '0; m_plot = 0; m_x = '0; m_y = '0; m_c = '0; m_terr = '0;
    end else if (m_rel) begin
      m_rel  = 0;
      m_plot = 0;
    end else if (m_owner < 0) begin
      m_plot = 0;
      w = pick();
      if (w >= 0) begin
        m_owner = w;
        m_age   = 0;
        m_grant = NUM_REQ'(1 << w);
      end
    end else begin
      o = m_owner;
      if (bus.plot_in[o]) begin
        m_x    = bus.x_in[o*X_W +: X_W];
        m_y    = bus.y_in[o*Y_W +: Y_W];
        m_c    = bus.color_in[o*C_W +: C_W];
        m_plot = (32'(m_x) < H_RES) && (32'(m_y) < V_RES);
      end else begin
        m_plot = 0;
      end
      if (bus.done[o] || !bus.req[o] || m_age == TIMEOUT - 1) begin
        if (m_age == TIMEOUT - 1) m_terr[o] = 1'b1;
        m_rel   = 1;
        m_grant = '0;
        if (o != 0) m_rr = (o == NUM_REQ - 1) ? 1 : o + 1;
        m_owner = -1;
      end else begin
        m_age++;
      end
    end
    m_busy = (m_owner >= 0) || m_rel;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("rnd_grant", 32'(bus.grant), 32'(m_grant));
    chk("rnd_plot",  32'(vga_plot),  32'(m_plot));
    chk("rnd_busy",  32'(busy),      32'(m_busy));
    chk("rnd_terr",  32'(timeout_err), 32'(m_terr));
    chk("rnd_x",     32'(vga_x),     32'(m_x));
    chk("rnd_y",     32'(vga_y),     32'(m_y));
    chk("rnd_color", 32'(vga_color), 32'(m_c));
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] d, input logic [2:0] p,
                       input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input logic [C_W-1:0] c);
    bus.req      = r;
    bus.done     = d;
    bus.plot_in  = p;
    bus.x_in     = {NUM_REQ{x}};
    bus.y_in     = {NUM_REQ{y}};
    bus.color_in = {NUM_REQ{c}};
  endtask

  typedef struct {
    logic           rstn;
    logic [2:0]     req;
    logic [2:0]     done;
    logic [2:0]     plot;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
    logic [2:0]     e_grant;
    logic           e_plot;
    logic           e_busy;
    logic [X_W-1:0] e_x;
    logic [Y_W-1:0] e_y;
    logic [C_W-1:0] e_c;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    logic [2:0] gq[$];
    int n;
    logic [X_W-1:0] rx;
    logic [Y_W-1:0] ry;

    //              rstn req     done    plot    x    y    c       grant  pl busy ex   ey   ec
    tbl[0]  = '{1'b0, 3'b111, 3'b000, 3'b000,   0,   0, 3'd0, 3'b000, 0, 0,   0,   0, 3'd0};
    tbl[1]  = '{1'b0, 3'b111, 3'b000, 3'b000,   0,   0, 3'd0, 3'b000, 0, 0,   0,   0, 3'd0};
    tbl[2]  = '{1'b1, 3'b010, 3'b000, 3'b000,   0,   0, 3'd0, 3'b010, 0, 1,   0,   0, 3'd0};
    tbl[3]  = '{1'b1, 3'b010, 3'b000, 3'b010,  10,  20, 3'd6, 3'b010, 1, 1,  10,  20, 3'd6};
    tbl[4]  = '{1'b1, 3'b010, 3'b000, 3'b000,   1,   1, 3'd0, 3'b010, 0, 1,  10,  20, 3'd6};
    tbl[5]  = '{1'b1, 3'b010, 3'b010, 3'b010, 319, 239, 3'd1, 3'b000, 1, 1, 319, 239, 3'd1};
    tbl[6]  = '{1'b1, 3'b000, 3'b000, 3'b000,   0,   0, 3'd0, 3'b000, 0, 0, 319, 239, 3'd1};
    tbl[7]  = '{1'b1, 3'b100, 3'b000, 3'b000,   0,   0, 3'd0, 3'b100, 0, 1, 319, 239, 3'd1};
    tbl[8]  = '{1'b1, 3'b100, 3'b000, 3'b100, 320,   0, 3'd2, 3'b100, 0, 1, 320,   0, 3'd2};
    tbl[9]  = '{1'b1, 3'b100, 3'b000, 3'b100,   0, 240, 3'd3, 3'b100, 0, 1,   0, 240, 3'd3};
    tbl[10] = '{1'b1, 3'b100, 3'b000, 3'b100,   5,   5, 3'd7, 3'b100, 1, 1,   5,   5, 3'd7};
    tbl[11] = '{1'b1, 3'b000, 3'b000, 3'b100,   6,   6, 3'd4, 3'b000, 1, 1,   6,   6, 3'd4};
    tbl[12] = '{1'b1, 3'b000, 3'b000, 3'b000,   0,   0, 3'd0, 3'b000, 0, 0,   6,   6, 3'd4};

    // Directed vector table: reset, latency, done-cycle pixel, clipping.
    for (int i = 0; i < 13; i++) begin
      resetn = tbl[i].rstn;
      drive(tbl[i].req, tbl[i].done, tbl[i].plot, tbl[i].x, tbl[i].y, tbl[i].c);
      tick();
      chk($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(tbl[i].e_grant));
      chk($sformatf("vec%0d_plot", i),  32'(vga_plot),  32'(tbl[i].e_plot));
      chk($sformatf("vec%0d_busy", i),  32'(busy),      32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_x", i),     32'(vga_x),     32'(tbl[i].e_x));
      chk($sformatf("vec%0d_y", i),     32'(vga_y),     32'(tbl[i].e_y));
      chk($sformatf("vec%0d_color", i), 32'(vga_color), 32'(tbl[i].e_c));
      chk($sformatf("vec%0d_terr", i),  32'(timeout_err), 32'(0));
    end

    // Fixed priority: requester 0 keeps winning while it asks.
    drive(3'b111, 3'b111, 3'b000, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.grant != 3'b000) gq.push_back(bus.grant);
    end
    chk("prio_count", 32'(gq.size()), 32'(3));
    for (int i = 0; i < gq.size(); i++) chk($sformatf("prio_g%0d", i), 32'(gq[i]), 32'(3'b001));

    // Round-robin between requesters 1 and 2 once requester 0 drops.
    gq.delete();
    drive(3'b110, 3'b110, 3'b000, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.grant != 3'b000) gq.push_back(bus.grant);
    end
    chk("rr_count", 32'(gq.size()), 32'(4));
    for (int i = 0; i < gq.size(); i++)
      chk($sformatf("rr_g%0d", i), 32'(gq[i]), 32'((i % 2 == 0) ? 3'b010 : 3'b100));
    drive(3'b000, 3'b000, 3'b000, 0, 0, 0);
    tick();

    // No pre-emption: requester 0 waits until requester 1 finishes.
    drive(3'b010, 3'b000, 3'b000, 0, 0, 0);
    tick();
    chk("npe_grant1", 32'(bus.grant), 32'(3'b010));
    drive(3'b011, 3'b000, 3'b000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("npe_hold%0d", i), 32'(bus.grant), 32'(3'b010));
    end
    drive(3'b011, 3'b010, 3'b000, 0, 0, 0);
    tick();
    chk("npe_rel", 32'(bus.grant), 32'(3'b000));
    chk("npe_rel_busy", 32'(busy), 32'(1));
    drive(3'b011, 3'b000, 3'b000, 0, 0, 0);
    tick();
    chk("npe_gap", 32'(bus.grant), 32'(3'b000));
    tick();
    chk("npe_grant0", 32'(bus.grant), 32'(3'b001));
    drive(3'b000, 3'b000, 3'b000, 0, 0, 0);
    tick();
    tick();

    // Watchdog: requester 1 never signals done.
    drive(3'b010, 3'b000, 3'b000, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.grant == 3'b010) n++;
      else if (n > 0) break;
    end
    drive(3'b000, 3'b000, 3'b000, 0, 0, 0);
    chk("wd_cycles", 32'(n), 32'(TIMEOUT));
    chk("wd_terr", 32'(timeout_err), 32'(3'b010));
    tick();
    tick();
    tick();
    chk("wd_sticky", 32'(timeout_err), 32'(3'b010));
    drive(3'b100, 3'b000, 3'b000, 0, 0, 0);
    tick();
    chk("wd_next_grant", 32'(bus.grant), 32'(3'b100));
    chk("wd_sticky2", 32'(timeout_err), 32'(3'b010));

    // Reset in the middle of a burst drops grant and blocks the pixel.
    resetn = 1'b0;
    drive(3'b100, 3'b000, 3'b100, 9'd1, 8'd1, 3'd5);
    tick();
    chk("rst_mid_grant", 32'(bus.grant), 32'(3'b000));
    chk("rst_mid_plot",  32'(vga_plot),  32'(0));
    chk("rst_mid_busy",  32'(busy),      32'(0));
    chk("rst_mid_terr",  32'(timeout_err), 32'(0));
    chk("rst_mid_x",     32'(vga_x),     32'(0));

    // Randomized traffic against the reference model.
    resetn = 1'b1;
    drive(3'b000, 3'b000, 3'b000, 0, 0, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      resetn = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
        bus.done[i]    = ($urandom_range(0, 5) == 0);
        bus.plot_in[i] = ($urandom_range(0, 3) != 0);
        rx = ($urandom_range(0, 3) == 0) ? X_W'($urandom_range(318, 321)) : X_W'($urandom_range(0, 511));
        ry = ($urandom_range(0, 3) == 0) ? Y_W'($urandom_range(238, 241)) : Y_W'($urandom_range(0, 255));
        bus.x_in[i*X_W +: X_W]     = rx;
        bus.y_in[i*Y_W +: Y_W]     = ry;
        bus.color_in[i*C_W +: C_W] = C_W'($urandom_range(0, 7));
      end
      tick();
      chk_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
